// File: rtl/vs_residual_updater.sv
// -----------------------------------------------------------------------------
// vs_residual_updater
//
// Purpose
//   One residual-update step of a greedy sparse-recovery loop. After the max
//   identifier selects column `location` with inner product `value`, this block
//   sweeps every row of that sensing-matrix column and rewrites the residual:
//
//       res[r] <= res[r] - (value >>> NORM_SHIFT) * phi[location][r]
//
//   NORM_SHIFT is log2 of the column squared norm, so the shifted value is the
//   projection coefficient. Arithmetic is 32-bit two's complement with wrap.
//   One row is processed per cycle through a short read/compute/write pipeline.
//
// Optional feature
//   VS_RESIDUAL_UPDATER_ENERGY_EN : when defined, residual_energy_o accumulates
//   the low 32 bits of the squares of the newly written residual rows. When it
//   is undefined, residual_energy_o is tied to zero and no multiply-accumulate
//   is built.
//
// Ports
//   clock_i             single clock, rising edge
//   reset_i             asynchronous active-high reset
//   start_i             request an update (sampled in IDLE only)
//   location_i [7:0]    selected column index
//   value_i    [31:0]   signed inner product of the selected column
//   phi_read_addr_o     sensing-matrix read address, column-major
//   phi_read_data_i     sensing-matrix data, one cycle after its address
//   res_read_addr_o     residual read address
//   res_read_data_i     residual data, one cycle after its address
//   res_write_*_o       residual write port (enable / address / data)
//   busy_o              high from accepted start until done
//   done_o              one-cycle completion pulse
//   bad_location_o      sticky flag: location >= COLUMNS on the last start
//   residual_energy_o   sum of squares of the updated residual (see above)
//
// Timing (start sampled at edge E0, ROWS = R)
//   E0        address of row 0 presented to both RAMs
//   Er        address of row r presented
//   E(r+2)    write of row r presented (committed by the RAM at E(r+3))
//   E(R+1)    last write presented, FSM enters FINISH
//   E(R+2)    done_o pulses, busy_o drops, FSM back to IDLE
// -----------------------------------------------------------------------------

// Structural invariants of the updater's outputs; carries no design logic.
module vs_residual_updater_checker (
  input logic clock_i,
  input logic reset_i,
  input logic busy_i,
  input logic done_i,
  input logic write_enable_i,
  input logic bad_location_i
);

  // done is a single-cycle pulse
  a_done_pulse : assert property (@(posedge clock_i) disable iff (reset_i)
    done_i |=> !done_i);

  // completion is reported only once the block has released busy
  a_done_not_busy : assert property (@(posedge clock_i) disable iff (reset_i)
    done_i |-> !busy_i);

  // residual writes only happen inside an update
  a_write_in_update : assert property (@(posedge clock_i) disable iff (reset_i)
    write_enable_i |-> busy_i);

  // a rejected column never touches the residual
  a_bad_no_write : assert property (@(posedge clock_i) disable iff (reset_i)
    bad_location_i |-> !write_enable_i);

endmodule

module vs_residual_updater #(
  parameter int ROWS       = 4,
  parameter int COLUMNS    = 8,
  parameter int NORM_SHIFT = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [7:0]  location_i,
  input  logic [31:0] value_i,
  output logic [15:0] phi_read_addr_o,
  input  logic [31:0] phi_read_data_i,
  output logic [7:0]  res_read_addr_o,
  input  logic [31:0] res_read_data_i,
  output logic        res_write_enable_o,
  output logic [7:0]  res_write_addr_o,
  output logic [31:0] res_write_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        bad_location_o,
  output logic [31:0] residual_energy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam logic [7:0]  LAST_ROW = 8'(ROWS - 1);
  localparam logic [8:0]  COLS9    = 9'(COLUMNS);
  localparam logic [15:0] ROWS16   = 16'(ROWS);

  state_t             state_q;
  logic signed [31:0] scaled_q;      // projection coefficient of this update
  logic               issue_q;       // an address is on the RAM ports this cycle
  logic               data_vld_q;    // RAM data for data_row_q is valid this cycle
  logic [7:0]         data_row_q;    // row whose data is on the RAM outputs
  logic [15:0]        phi_addr_q;
  logic [7:0]         res_addr_q;    // doubles as the row counter
  logic               wen_q;
  logic [7:0]         waddr_q;
  logic [31:0]        wdata_q;
  logic               busy_q;
  logic               done_q;
  logic               bad_q;

  logic               loc_ok_d;
  logic [15:0]        col_base_d;
  logic signed [31:0] scaled_d;
  logic signed [31:0] prod_d;
  logic signed [31:0] new_res_d;

  // Acceptance-time values: column check, column base address, shifted value.
  // The base address captured at start is the latched form of location.
  assign loc_ok_d   = ({1'b0, location_i} < COLS9);
  assign col_base_d = {8'd0, location_i} * ROWS16;
  assign scaled_d   = $signed(value_i) >>> NORM_SHIFT;

  // Row update; both operations keep only the low 32 bits (wrap, no saturation).
  assign prod_d    = scaled_q * $signed(phi_read_data_i);
  assign new_res_d = $signed(res_read_data_i) - prod_d;

  // Control FSM with address generation, write pipeline and status flags.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      scaled_q   <= 32'sd0;
      issue_q    <= 1'b0;
      data_vld_q <= 1'b0;
      data_row_q <= 8'd0;
      phi_addr_q <= 16'd0;
      res_addr_q <= 8'd0;
      wen_q      <= 1'b0;
      waddr_q    <= 8'd0;
      wdata_q    <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      // Pulses default low; the read pipeline advances every cycle.
      done_q     <= 1'b0;
      wen_q      <= 1'b0;
      data_vld_q <= issue_q;
      data_row_q <= res_addr_q;

      case (state_q)
        ST_IDLE: begin
          issue_q <= 1'b0;
          if (start_i) begin
            busy_q   <= 1'b1;
            bad_q    <= ~loc_ok_d;
            scaled_q <= scaled_d;
            if (loc_ok_d) begin
              // Row 0 is presented to both RAMs straight away.
              state_q    <= ST_SWEEP;
              issue_q    <= 1'b1;
              phi_addr_q <= col_base_d;
              res_addr_q <= 8'd0;
            end else begin
              // Nothing to sweep: report completion on the next cycle.
              state_q <= ST_FINISH;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_SWEEP: begin
          // Issue side: walk down the column, stop after the last row.
          if (issue_q && (res_addr_q != LAST_ROW)) begin
            phi_addr_q <= phi_addr_q + 16'd1;
            res_addr_q <= res_addr_q + 8'd1;
          end else begin
            issue_q <= 1'b0;
          end

          // Write side: data of the row issued two edges ago is on the RAM
          // outputs now. Each row is read once before its own write, so the
          // read can never observe a value this sweep already wrote.
          if (data_vld_q) begin
            wen_q   <= 1'b1;
            waddr_q <= data_row_q;
            wdata_q <= new_res_d;
            if (data_row_q == LAST_ROW) begin
              state_q <= ST_FINISH;
            end else begin
              state_q <= ST_SWEEP;
            end
          end else begin
            state_q <= ST_SWEEP;
          end
        end

        ST_FINISH: begin
          // The last write (if any) is on the port during this state.
          state_q <= ST_IDLE;
          issue_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end

        default: begin
          state_q <= ST_IDLE;
          issue_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef VS_RESIDUAL_UPDATER_ENERGY_EN
  logic [31:0] energy_q;
  logic [31:0] square_d;

  // Square of the row currently being written, low 32 bits.
  assign square_d = wdata_q * wdata_q;

  // Energy accumulator: cleared on an accepted start, adds each written row,
  // holds after done until the next start.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      energy_q <= 32'd0;
    end else if ((state_q == ST_IDLE) && start_i) begin
      energy_q <= 32'd0;
    end else if (wen_q) begin
      energy_q <= energy_q + square_d;
    end else begin
      energy_q <= energy_q;
    end
  end

  assign residual_energy_o = energy_q;
`else
  assign residual_energy_o = 32'd0;
`endif

  assign phi_read_addr_o    = phi_addr_q;
  assign res_read_addr_o    = res_addr_q;
  assign res_write_enable_o = wen_q;
  assign res_write_addr_o   = waddr_q;
  assign res_write_data_o   = wdata_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign bad_location_o     = bad_q;

  vs_residual_updater_checker u_checker (
    .clock_i        (clock_i),
    .reset_i        (reset_i),
    .busy_i         (busy_q),
    .done_i         (done_q),
    .write_enable_i (wen_q),
    .bad_location_i (bad_q)
  );

endmodule

// File: tb/tb_vs_residual_updater.sv
module tb_vs_residual_updater;

  localparam int ROWS    = 4;
  localparam int COLUMNS = 8;
  localparam int NSHIFT  = 2;
  localparam int PERIOD  = 10;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  loc;
  logic [31:0] val;
  logic [15:0] phi_addr;
  logic [31:0] phi_rd;
  logic [7:0]  res_addr;
  logic [31:0] res_rd;
  logic        wen;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        bad_location;
  logic [31:0] energy;

  vs_residual_updater #(.ROWS(ROWS), .COLUMNS(COLUMNS), .NORM_SHIFT(NSHIFT)) dut (
    .clock_i            (clk),
    .reset_i            (rst),
    .start_i            (start),
    .location_i         (loc),
    .value_i            (val),
    .phi_read_addr_o    (phi_addr),
    .phi_read_data_i    (phi_rd),
    .res_read_addr_o    (res_addr),
    .res_read_data_i    (res_rd),
    .res_write_enable_o (wen),
    .res_write_addr_o   (waddr),
    .res_write_data_o   (wdata),
    .busy_o             (busy),
    .done_o             (done),
    .bad_location_o     (bad_location),
    .residual_energy_o  (energy)
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  // ---------------- memories seen by the DUT ----------------
  int  phi_mem [COLUMNS*ROWS];
  int  res_mem [ROWS];
  logic load_en;
  int  load_val [ROWS];

  always @(posedge clk) begin
    phi_rd <= (phi_addr < 16'(COLUMNS*ROWS)) ? phi_mem[phi_addr] : 32'hDEAD_BEEF;
    res_rd <= (res_addr < 8'(ROWS)) ? res_mem[res_addr] : 32'hDEAD_BEEF;
    if (load_en) begin
      for (int r = 0; r < ROWS; r++) res_mem[r] <= load_val[r];
    end else if (wen && (waddr < 8'(ROWS))) begin
      res_mem[waddr] <= wdata;
    end
  end

  // ---------------- reference model and expectations ----------------
  typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
  wr_t exp_wq [$];
  int  res_model [ROWS];
  int  exp_new   [ROWS];
  int  exp_energy;
  bit  exp_bad;
  time exp_done_t;
  int  total;
  int  bad;
  int  done_cnt;

  // floor(v / 2^NSHIFT) by ordinary integer division
  function automatic int floor_div(input int v);
    int d;
    int q;
    d = 1 << NSHIFT;
    q = v / d;
    if (v < 0 && q * d != v) q = q - 1;
    return q;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d (0x%08h) want %0d (0x%08h)", name, $signed(act), act, $signed(want), want);
    end
  endtask

  // compare process: every write and every done against the model
  always @(negedge clk) begin
    if (!rst) begin
      if (wen) begin
        total++;
        if (exp_wq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: addr %0d data %0d at %0t", waddr, $signed(wdata), $time);
        end else begin
          wr_t w;
          w = exp_wq.pop_front();
          if (waddr !== w.a || wdata !== w.d) begin
            bad++;
            $display("FAIL write: got addr %0d data %0d want addr %0d data %0d", waddr, $signed(wdata), w.a, $signed(w.d));
          end
        end
      end
      if (done) begin
        total++;
        if ($time != exp_done_t) begin
          bad++;
          $display("FAIL done_time: got %0t want %0t", $time, exp_done_t);
        end
        total++;
        if (energy !== exp_energy) begin
          bad++;
          $display("FAIL energy: got %0d want %0d", $signed(energy), exp_energy);
        end
        total++;
        if (bad_location !== exp_bad) begin
          bad++;
          $display("FAIL bad_location_at_done: got %0b want %0b", bad_location, exp_bad);
        end
        total++;
        if (exp_wq.size() != 0) begin
          bad++;
          $display("FAIL missing_writes: got %0d pending want 0", exp_wq.size());
        end
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL busy_at_done: got %0b want 0", busy);
        end
        done_cnt++;
        exp_done_t = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_res(input int v0, input int v1, input int v2, input int v3);
    @(negedge clk);
    load_val[0] = v0; load_val[1] = v1; load_val[2] = v2; load_val[3] = v3;
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    for (int r = 0; r < ROWS; r++) res_model[r] = load_val[r];
  endtask

  // Build expectations from the update rule, then pulse start for one cycle.
  task automatic launch(input int l, input int v);
    int sc;
    int nv;
    wr_t w;
    @(negedge clk);
    exp_energy = 0;
    if (l >= COLUMNS) begin
      exp_bad    = 1'b1;
      exp_done_t = $time + 2 * PERIOD;
      for (int r = 0; r < ROWS; r++) exp_new[r] = res_model[r];
    end else begin
      exp_bad    = 1'b0;
      exp_done_t = $time + (ROWS + 3) * PERIOD;
      sc = floor_div(v);
      for (int r = 0; r < ROWS; r++) begin
        nv = res_model[r] - sc * phi_mem[l * ROWS + r];
        exp_new[r] = nv;
        exp_energy = exp_energy + nv * nv;
        w.a = 8'(r);
        w.d = nv;
        exp_wq.push_back(w);
      end
    end
`ifndef VS_RESIDUAL_UPDATER_ENERGY_EN
    exp_energy = 0;
`endif
    loc   = 8'(l);
    val   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done within 40 cycles want done");
    end
    for (int r = 0; r < ROWS; r++) res_model[r] = exp_new[r];
  endtask

  task automatic check_res(input string name, input int v0, input int v1, input int v2, input int v3);
    int lit [ROWS];
    lit[0] = v0; lit[1] = v1; lit[2] = v2; lit[3] = v3;
    for (int r = 0; r < ROWS; r++) begin
      chk({name, "_ram"}, res_mem[r], lit[r]);
      chk({name, "_model"}, res_model[r], lit[r]);
    end
  endtask

  task automatic check_zero(input string name);
    chk(name, {busy, done, wen, bad_location, phi_addr, res_addr, waddr, wdata, energy} == '0 ? 32'd0 : 32'd1, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int dc;
    total = 0; bad = 0; done_cnt = 0;
    exp_done_t = 0; exp_energy = 0; exp_bad = 1'b0;
    rst = 1'b1; start = 1'b0; loc = 8'd0; val = 32'd0; load_en = 1'b0;
    for (int i = 0; i < ROWS; i++) load_val[i] = 0;
    for (int c = 0; c < COLUMNS; c++)
      for (int r = 0; r < ROWS; r++)
        phi_mem[c * ROWS + r] = ((c + r) % 2 == 1) ? -1 : 1;
    phi_mem[4]  = 1;  phi_mem[5]  = 1;  phi_mem[6]  = -1; phi_mem[7]  = -1;
    phi_mem[12] = 1;  phi_mem[13] = -1; phi_mem[14] = 1;  phi_mem[15] = -1;
    phi_mem[20] = 32'h4000_0001; phi_mem[21] = -7; phi_mem[22] = 32'h7fff_ffff; phi_mem[23] = 3;

    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    rst = 1'b0;
    load_res(1, 2, -2, 1);

    // column 1, value 4 -> scaled 1
    launch(1, 4);
    chk("busy_in_sweep", {31'd0, busy}, 32'd1);
    wait_done();
    check_res("col1_v4", 0, 1, -1, 2);
    repeat (2) @(negedge clk);
`ifdef VS_RESIDUAL_UPDATER_ENERGY_EN
    chk("energy_hold", energy, 32'd6);
`else
    chk("energy_hold", energy, 32'd0);
`endif

    // back-to-back: recomputed inner product is 0 -> unchanged, still 4 writes
    launch(1, 0);
    wait_done();
    check_res("col1_v0", 0, 1, -1, 2);

    // column 3, value -4 and -3 -> both scaled -1
    load_res(1, 2, -2, 1);
    launch(3, -4);
    wait_done();
    check_res("col3_vm4", 2, 1, -1, 0);
    load_res(1, 2, -2, 1);
    launch(3, -3);
    wait_done();
    check_res("col3_vm3", 2, 1, -1, 0);

    // out-of-range column
    load_res(1, 2, -2, 1);
    launch(8, 100);
    wait_done();
    repeat (3) @(negedge clk);
    chk("bad_sticky", {31'd0, bad_location}, 32'd1);
    check_res("bad_loc_unchanged", 1, 2, -2, 1);

    // valid start clears bad_location; stray start mid-sweep is ignored
    dc = done_cnt;
    launch(1, 4);
    chk("bad_cleared", {31'd0, bad_location}, 32'd0);
    @(negedge clk);
    loc = 8'd3; val = 32'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);
    chk("single_done", done_cnt - dc, 32'd1);
    check_res("col1_ignore_start", 0, 1, -1, 2);

    // reset mid-sweep after rows 0-1 are committed
    load_res(1, 2, -2, 1);
    launch(1, 4);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1 check_zero("reset_mid_sweep");
    exp_wq.delete();
    exp_done_t = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    res_model[0] = exp_new[0];
    res_model[1] = exp_new[1];
    repeat (2) @(negedge clk);
    check_res("reset_partial", 0, 1, -2, 1);

    // fresh start after reset: col1 . {0,1,-2,1} = 2, value 8 -> scaled 2
    launch(1, 8);
    wait_done();
    check_res("after_reset", -2, -1, 0, 3);

    // wrapping products and a negative non-multiple value
    launch(5, 32'h7fff_fff3);
    wait_done();
    launch(2, -5);
    wait_done();
    for (int r = 0; r < ROWS; r++) chk("wrap_model_ram", res_mem[r], res_model[r]);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vs_residual_updater.md
VS_RESIDUAL_UPDATER -- requirements
Module: vs_residual_updater

Interface
REQ-001 Parameter ROWS, default 4: number of rows per sensing-matrix column and residual length.
REQ-002 Parameter COLUMNS, default 8: number of sensing-matrix columns.
REQ-003 Parameter NORM_SHIFT, default 2: log2 of the column squared norm; equals log2(ROWS) for +/-1 matrices.
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  request one residual update; sampled only in IDLE.
REQ-007 location  in  8  selected column index (max identifier output).
REQ-008 value  in  32  signed inner product of the selected column (max identifier output).
REQ-009 phi_read_addr  out  16  sensing-matrix RAM read address, column-major (location*ROWS + row).
REQ-010 phi_read_data  in  32  sensing-matrix RAM data, valid one cycle after its address.
REQ-011 res_read_addr  out  8  residual RAM read address.
REQ-012 res_read_data  in  32  residual RAM data, valid one cycle after its address.
REQ-013 res_write_enable, res_write_addr, res_write_data  out  1/8/32  residual RAM write port.
REQ-014 busy  out  1  high from accepted start until done.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 bad_location  out  1  sticky until next accepted start; high when location >= COLUMNS.
REQ-017 residual_energy  out  32  sum of squares of the updated residual; valid while done is high.

Function
REQ-018 States IDLE, SWEEP, FINISH; IDLE->SWEEP on start; SWEEP->FINISH after the last row is written; FINISH->IDLE unconditionally.
REQ-019 On accepted start: latch location; latch scaled = value >>> NORM_SHIFT (arithmetic shift, rounds toward minus infinity); clear row counter, bad_location, energy accumulator.
REQ-020 Row r address issued on SWEEP cycle r to both RAMs; on cycle r+1 write res[r] = res_read_data - scaled*phi_read_data to address r.
REQ-021 Product and difference use the low 32 bits, two's-complement wrap; no saturation.
REQ-022 Throughput is one row per cycle; done asserts exactly ROWS+2 cycles after the start-sampling edge.
REQ-023 value=0 still performs all ROWS writes, with unchanged data.
REQ-024 location >= COLUMNS: no writes, bad_location=1, done pulses on the following cycle.
REQ-025 start while busy is ignored; start held high through done re-triggers only after IDLE is re-entered.
REQ-026 Read-after-write hazard cannot occur: row r is read exactly once, before its write.
REQ-027 res_write_enable is never high outside SWEEP/FINISH.

Reset
REQ-028 reset forces IDLE immediately; busy, done, res_write_enable, bad_location = 0; all addresses = 0; residual_energy = 0.
REQ-029 reset mid-sweep abandons the update; already-written rows stay modified, and no further writes occur.

Configuration
REQ-030 With VS_RESIDUAL_UPDATER_ENERGY_EN defined, residual_energy accumulates (new res[r])^2 (low 32 bits) per written row and holds after done until the next start.
REQ-031 Without VS_RESIDUAL_UPDATER_ENERGY_EN, residual_energy is constant 0 and no multiplier-accumulator is built.

Verification
REQ-032 Residual {1,2,-2,1}, column 1 {1,1,-1,-1}, value=4 -> residual {0,1,-1,2}; done at start+6 cycles; energy 6 (macro on), 0 (macro off).
REQ-033 Same residual, column 3 {1,-1,1,-1}, value=-4 -> scaled -1, residual {2,1,-1,0}; also value=-3 -> scaled -1, same result.
REQ-034 location=8 -> zero writes, bad_location=1, done one cycle after start; next valid start clears bad_location.
REQ-035 start pulsed again on SWEEP cycle 2 -> ignored; exactly 4 writes, one done pulse.
REQ-036 reset asserted after 2 rows written -> outputs zero immediately; rows 0-1 updated, rows 2-3 unchanged; a fresh start works.
REQ-037 Back-to-back updates (column 1 then column 1 with value recomputed=0) -> second sweep leaves residual unchanged.
